// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings and defaults for the I/D-cache memory arbiter.
//   FSM state encodings, owner encoding, default parameter values and the
//   {valid, owner} read-return tag carried through the return pipeline.
package mem_arbiter_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 16;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'b00;
    localparam logic [STATE_W-1:0] ST_GNT_I = 2'b01;
    localparam logic [STATE_W-1:0] ST_GNT_D = 2'b10;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam bit          DEF_PRIO_D    = 1'b1;
    localparam int unsigned DEF_MAX_BURST = 8;
    localparam int unsigned DEF_RD_LAT    = 2;

    // Tag attached to each accepted read so its data can be steered on return.
    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/mem_arbiter_rd_tag_pipe.sv
// mem_arbiter_rd_tag_pipe: RD_LAT-deep {valid, owner} shift register.
//   Loaded every cycle with the tag of the current access (valid only for an
//   accepted read); the tail lines up with mem_data_out of that read.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_owner  tag entering the pipe this cycle
//   out_valid, out_owner tag leaving the pipe (RD_LAT cycles later)
module mem_arbiter_rd_tag_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_owner,
    output logic out_valid,
    output logic out_owner
);

    localparam int unsigned TAG_W = $bits(rd_tag_t);

    // chain[0] is the incoming tag; chain[i+1] is the output of flop stage i.
    logic [RD_LAT:0][TAG_W-1:0] chain;
    rd_tag_t                    tail;

    assign chain[0] = {in_valid, in_owner};

    // One async-reset flop stage per cycle of read latency.
    for (genvar i = 0; i < RD_LAT; i++) begin : g_dff
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                chain[i+1] <= '0;
            end else begin
                chain[i+1] <= chain[i];
            end
        end
    end

    assign tail      = rd_tag_t'(chain[RD_LAT]);
    assign out_valid = tail.valid;
    assign out_owner = tail.owner;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares main memory between the I-cache and D-cache controllers.
//   Grants memory for a whole miss burst, forwards the owner's access, stalls
//   the other requester, and tags accepted reads so returning data is flagged
//   for the requester that issued it.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   ic_rd/ic_wr/ic_addr/ic_data_in   I-cache controller request
//   dc_rd/dc_wr/dc_addr/dc_data_in   D-cache controller request
//   mem_stall, mem_data_out          memory bank-busy and read data
//   mem_rd/mem_wr/mem_addr/mem_data_in  forwarded access to memory
//   ic_stall/dc_stall                stall back to each controller
//   ic_rdata/dc_rdata, ic_rvalid/dc_rvalid  read return per requester
//   ic_grant/dc_grant                current owner indication
//   err                              protocol error pulse
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit          PRIO_D    = DEF_PRIO_D,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST,
    parameter int unsigned RD_LAT    = DEF_RD_LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ic_rd,
    input  logic        ic_wr,
    input  logic [15:0] ic_addr,
    input  logic [15:0] ic_data_in,
    input  logic        dc_rd,
    input  logic        dc_wr,
    input  logic [15:0] dc_addr,
    input  logic [15:0] dc_data_in,
    input  logic        mem_stall,
    input  logic [15:0] mem_data_out,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        ic_stall,
    output logic        dc_stall,
    output logic [15:0] ic_rdata,
    output logic [15:0] dc_rdata,
    output logic        ic_rvalid,
    output logic        dc_rvalid,
    output logic        ic_grant,
    output logic        dc_grant,
    output logic        err
);

    localparam int unsigned CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    logic [STATE_W-1:0] state, state_nxt;
    logic               last_served, last_served_nxt;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_nxt, cnt_base;

    logic        req_i, req_d;
    logic        free, arb_last, bad_state;
    logic        own_valid, owner, act;
    logic        sel_rd, sel_wr;
    logic [15:0] sel_addr, sel_data;
    logic        accepted, cnt_full;
    logic        tag_in_valid;
    logic        tag_out_valid, tag_out_owner;

    assign req_i = ic_rd | ic_wr;
    assign req_d = dc_rd | dc_wr;

    // State, last-served owner and burst counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            last_served <= OWN_I;
            burst_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            last_served <= last_served_nxt;
            burst_cnt   <= burst_cnt_nxt;
        end
    end

    // Next-state, arbitration and output decode.
    always_comb begin
        state_nxt       = state;
        last_served_nxt = last_served;
        burst_cnt_nxt   = burst_cnt;
        free            = 1'b0;
        arb_last        = last_served;
        bad_state       = 1'b0;
        own_valid       = 1'b0;
        owner           = OWN_I;
        sel_rd          = 1'b0;
        sel_wr          = 1'b0;
        sel_addr        = '0;
        sel_data        = '0;
        act             = 1'b0;
        mem_rd          = 1'b0;
        mem_wr          = 1'b0;
        mem_addr        = '0;
        mem_data_in     = '0;
        ic_grant        = 1'b0;
        dc_grant        = 1'b0;
        accepted        = 1'b0;
        cnt_base        = '0;
        cnt_full        = 1'b0;
        err             = 1'b0;
        tag_in_valid    = 1'b0;

        // An owner dropping req releases the grant this very cycle, so the
        // cycle is arbitrated as IDLE with that owner as last served.
        case (state)
            ST_IDLE: begin
                free = 1'b1;
            end
            ST_GNT_I: begin
                if (req_i) begin
                    own_valid = 1'b1;
                    owner     = OWN_I;
                end else begin
                    free            = 1'b1;
                    arb_last        = OWN_I;
                    last_served_nxt = OWN_I;
                end
            end
            ST_GNT_D: begin
                if (req_d) begin
                    own_valid = 1'b1;
                    owner     = OWN_D;
                end else begin
                    free            = 1'b1;
                    arb_last        = OWN_D;
                    last_served_nxt = OWN_D;
                end
            end
            default: begin
                bad_state = 1'b1;
            end
        endcase

        if (free) begin
            if (req_i && req_d) begin
                own_valid = 1'b1;
                owner     = PRIO_D ? OWN_D : ~arb_last;
            end else if (req_i) begin
                own_valid = 1'b1;
                owner     = OWN_I;
            end else if (req_d) begin
                own_valid = 1'b1;
                owner     = OWN_D;
            end
        end

        if (bad_state || !own_valid) begin
            state_nxt = ST_IDLE;
        end else begin
            state_nxt = (owner == OWN_D) ? ST_GNT_D : ST_GNT_I;
        end

        // Forward the owner's access; rd & wr together is treated as a read.
        sel_rd   = (owner == OWN_D) ? dc_rd      : ic_rd;
        sel_wr   = (owner == OWN_D) ? dc_wr      : ic_wr;
        sel_addr = (owner == OWN_D) ? dc_addr    : ic_addr;
        sel_data = (owner == OWN_D) ? dc_data_in : ic_data_in;

        act         = own_valid & rst;
        mem_rd      = act & sel_rd;
        mem_wr      = act & sel_wr & ~sel_rd;
        mem_addr    = act ? sel_addr : '0;
        mem_data_in = act ? sel_data : '0;
        ic_grant    = act & (owner == OWN_I);
        dc_grant    = act & (owner == OWN_D);

        // A fresh grant starts its count from zero in the cycle it is given.
        accepted = (mem_rd | mem_wr) & ~mem_stall;
        cnt_base = free ? '0 : burst_cnt;
        cnt_full = (cnt_base == CNT_MAX);
        if (!own_valid) begin
            burst_cnt_nxt = '0;
        end else if (accepted && !cnt_full) begin
            burst_cnt_nxt = cnt_base + CNT_W'(1);
        end else begin
            burst_cnt_nxt = cnt_base;
        end

        err = rst & (bad_state | (ic_rd & ic_wr) | (dc_rd & dc_wr) | (accepted & cnt_full));

        tag_in_valid = accepted & mem_rd;
    end

    // Granted requester sees the memory stall; any other requester waits.
    assign ic_stall = ic_grant ? mem_stall : req_i;
    assign dc_stall = dc_grant ? mem_stall : req_d;

    assign ic_rdata = mem_data_out;
    assign dc_rdata = mem_data_out;

    mem_arbiter_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk       (clk),
        .rst_n     (rst),
        .in_valid  (tag_in_valid),
        .in_owner  (owner),
        .out_valid (tag_out_valid),
        .out_owner (tag_out_owner)
    );

    assign ic_rvalid = tag_out_valid & (tag_out_owner == OWN_I);
    assign dc_rvalid = tag_out_valid & (tag_out_owner == OWN_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
//   Two instances share all inputs: p1 (data cache priority) and p0
//   (round-robin). Inputs change on the falling edge; outputs are sampled
//   1 time unit later, well away from the rising edge.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ic_rd, ic_wr, dc_rd, dc_wr, mem_stall;
    logic [15:0] ic_addr, ic_data_in, dc_addr, dc_data_in, mem_data_out;

    logic        p1_mem_rd, p1_mem_wr, p1_ic_stall, p1_dc_stall;
    logic        p1_ic_rvalid, p1_dc_rvalid, p1_ic_grant, p1_dc_grant, p1_err;
    logic [15:0] p1_mem_addr, p1_mem_data_in, p1_ic_rdata, p1_dc_rdata;

    logic        p0_mem_rd, p0_mem_wr, p0_ic_stall, p0_dc_stall;
    logic        p0_ic_rvalid, p0_dc_rvalid, p0_ic_grant, p0_dc_grant, p0_err;
    logic [15:0] p0_mem_addr, p0_mem_data_in, p0_ic_rdata, p0_dc_rdata;

    int n_chk;
    int n_fail;

    mem_arbiter #(.PRIO_D(1'b1), .MAX_BURST(8), .RD_LAT(2)) u_dut_p1 (
        .clk(clk), .rst(rst),
        .ic_rd(ic_rd), .ic_wr(ic_wr), .ic_addr(ic_addr), .ic_data_in(ic_data_in),
        .dc_rd(dc_rd), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_data_in(dc_data_in),
        .mem_stall(mem_stall), .mem_data_out(mem_data_out),
        .mem_rd(p1_mem_rd), .mem_wr(p1_mem_wr), .mem_addr(p1_mem_addr),
        .mem_data_in(p1_mem_data_in),
        .ic_stall(p1_ic_stall), .dc_stall(p1_dc_stall),
        .ic_rdata(p1_ic_rdata), .dc_rdata(p1_dc_rdata),
        .ic_rvalid(p1_ic_rvalid), .dc_rvalid(p1_dc_rvalid),
        .ic_grant(p1_ic_grant), .dc_grant(p1_dc_grant), .err(p1_err)
    );

    mem_arbiter #(.PRIO_D(1'b0), .MAX_BURST(8), .RD_LAT(2)) u_dut_p0 (
        .clk(clk), .rst(rst),
        .ic_rd(ic_rd), .ic_wr(ic_wr), .ic_addr(ic_addr), .ic_data_in(ic_data_in),
        .dc_rd(dc_rd), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_data_in(dc_data_in),
        .mem_stall(mem_stall), .mem_data_out(mem_data_out),
        .mem_rd(p0_mem_rd), .mem_wr(p0_mem_wr), .mem_addr(p0_mem_addr),
        .mem_data_in(p0_mem_data_in),
        .ic_stall(p0_ic_stall), .dc_stall(p0_dc_stall),
        .ic_rdata(p0_ic_rdata), .dc_rdata(p0_dc_rdata),
        .ic_rvalid(p0_ic_rvalid), .dc_rvalid(p0_dc_rvalid),
        .ic_grant(p0_ic_grant), .dc_grant(p0_dc_grant), .err(p0_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        ic_rd = 1'b0; ic_wr = 1'b0; ic_addr = '0; ic_data_in = '0;
        dc_rd = 1'b0; dc_wr = 1'b0; dc_addr = '0; dc_data_in = '0;
        mem_stall = 1'b0; mem_data_out = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_in();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        idle_in();

        // Reset state: everything 0; stall follows request while in reset.
        #2;
        chk("rst_ic_grant", 32'(p1_ic_grant), 32'd0);
        chk("rst_dc_grant", 32'(p1_dc_grant), 32'd0);
        chk("rst_mem_rd",   32'(p1_mem_rd),   32'd0);
        chk("rst_err",      32'(p1_err),      32'd0);
        chk("rst_dc_rvalid",32'(p1_dc_rvalid),32'd0);
        ic_rd = 1'b1;
        #1;
        chk("rst_ic_stall_req", 32'(p1_ic_stall), 32'd1);
        chk("rst_ic_grant_req", 32'(p1_ic_grant), 32'd0);
        chk("rst_mem_addr",     32'(p1_mem_addr), 32'd0);
        ic_rd = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // D-cache read burst of 4, I-cache idle.
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            dc_rd        = (k < 4);
            dc_addr      = (k < 4) ? 16'(16'h1200 + 2 * k) : 16'h0000;
            mem_data_out = 16'(16'hA000 + k);
            #1;
            chk("dr_dc_grant",  32'(p1_dc_grant),  (k < 4) ? 32'd1 : 32'd0);
            chk("dr_mem_addr",  32'(p1_mem_addr),  (k < 4) ? 32'(16'h1200 + 2 * k) : 32'd0);
            chk("dr_mem_rd",    32'(p1_mem_rd),    (k < 4) ? 32'd1 : 32'd0);
            chk("dr_dc_stall",  32'(p1_dc_stall),  32'd0);
            chk("dr_ic_stall",  32'(p1_ic_stall),  32'd0);
            chk("dr_dc_rvalid", 32'(p1_dc_rvalid), (k >= 2 && k <= 5) ? 32'd1 : 32'd0);
            chk("dr_ic_rvalid", 32'(p1_ic_rvalid), 32'd0);
            chk("dr_dc_rdata",  32'(p1_dc_rdata),  32'(16'hA000 + k));
        end

        // Simultaneous ic_rd and dc_wr: D wins an 8-write burst, then I.
        do_reset();
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            ic_rd      = (k < 10);
            ic_addr    = 16'h0100;
            dc_wr      = (k < 8);
            dc_addr    = 16'(16'h3000 + k);
            dc_data_in = 16'(16'h5500 + k);
            #1;
            if (k < 8) begin
                chk("pd_dc_grant", 32'(p1_dc_grant),    32'd1);
                chk("pd_ic_grant", 32'(p1_ic_grant),    32'd0);
                chk("pd_ic_stall", 32'(p1_ic_stall),    32'd1);
                chk("pd_mem_wr",   32'(p1_mem_wr),      32'd1);
                chk("pd_wdata",    32'(p1_mem_data_in), 32'(16'h5500 + k));
                chk("pd_err",      32'(p1_err),         32'd0);
            end else if (k < 10) begin
                chk("pd_ic_grant_after", 32'(p1_ic_grant), 32'd1);
                chk("pd_dc_grant_after", 32'(p1_dc_grant), 32'd0);
                chk("pd_ic_stall_after", 32'(p1_ic_stall), 32'd0);
                chk("pd_mem_rd_after",   32'(p1_mem_rd),   32'd1);
                chk("pd_mem_addr_after", 32'(p1_mem_addr), 32'h0100);
            end else begin
                chk("pd_ic_rvalid", 32'(p1_ic_rvalid), 32'd1);
                chk("pd_dc_rvalid", 32'(p1_dc_rvalid), 32'd0);
            end
        end

        // Round-robin: both request in rounds; p0 alternates D,I,D,I; p1 always D.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                ic_rd   = (c < 2);
                dc_rd   = (c < 2);
                ic_addr = 16'(16'h0A00 + r);
                dc_addr = 16'(16'h0D00 + r);
                #1;
                if (c < 2) begin
                    chk("rr_p0_dc_grant", 32'(p0_dc_grant), (r % 2 == 0) ? 32'd1 : 32'd0);
                    chk("rr_p0_ic_grant", 32'(p0_ic_grant), (r % 2 == 0) ? 32'd0 : 32'd1);
                    chk("rr_p0_mem_addr", 32'(p0_mem_addr),
                        (r % 2 == 0) ? 32'(16'h0D00 + r) : 32'(16'h0A00 + r));
                    chk("rr_p1_dc_grant", 32'(p1_dc_grant), 32'd1);
                end else begin
                    chk("rr_p0_released", 32'({p0_ic_grant, p0_dc_grant}), 32'd0);
                end
            end
        end

        // I-cache 4-read burst followed at once by a D write.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            ic_rd   = (k < 4);
            ic_addr = 16'(16'h2000 + k);
            dc_wr   = (k == 4 || k == 5);
            dc_addr = 16'h4400;
            #1;
            chk("hand_ic_rvalid", 32'(p1_ic_rvalid), (k >= 2 && k <= 5) ? 32'd1 : 32'd0);
            chk("hand_dc_rvalid", 32'(p1_dc_rvalid), 32'd0);
            if (k == 4 || k == 5) begin
                chk("hand_dc_grant", 32'(p1_dc_grant), 32'd1);
                chk("hand_ic_grant", 32'(p1_ic_grant), 32'd0);
            end
        end

        // mem_stall for 3 cycles mid-burst: accepts at k=0,4,5.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            dc_rd     = (k < 6);
            dc_addr   = 16'(16'h4000 + k);
            mem_stall = (k >= 1 && k <= 3);
            #1;
            if (k < 6) begin
                chk("st_dc_stall", 32'(p1_dc_stall), (k >= 1 && k <= 3) ? 32'd1 : 32'd0);
                chk("st_dc_grant", 32'(p1_dc_grant), 32'd1);
            end
            chk("st_dc_rvalid", 32'(p1_dc_rvalid), (k == 2 || k == 6 || k == 7) ? 32'd1 : 32'd0);
        end

        // Burst overflow: the 9th accepted access in one grant pulses err.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            dc_wr   = (k < 10) || (k == 11);
            dc_addr = 16'(16'h6000 + k);
            #1;
            if (k <= 8) begin
                chk("ov_err", 32'(p1_err), (k == 8) ? 32'd1 : 32'd0);
                chk("ov_mem_wr", 32'(p1_mem_wr), 32'd1);
            end else if (k == 10) begin
                chk("ov_err_idle", 32'(p1_err), 32'd0);
                chk("ov_grant_idle", 32'(p1_dc_grant), 32'd0);
            end else if (k == 11) begin
                chk("ov_err_new_grant", 32'(p1_err), 32'd0);
                chk("ov_grant_new", 32'(p1_dc_grant), 32'd1);
            end
        end

        // ic_rd & ic_wr together: err, forwarded as a read.
        do_reset();
        @(negedge clk);
        ic_rd = 1'b1; ic_wr = 1'b1; ic_addr = 16'h7777;
        #1;
        chk("rw_err",      32'(p1_err),      32'd1);
        chk("rw_ic_grant", 32'(p1_ic_grant), 32'd1);
        chk("rw_mem_rd",   32'(p1_mem_rd),   32'd1);
        chk("rw_mem_wr",   32'(p1_mem_wr),   32'd0);
        @(negedge clk);
        idle_in();
        #1;
        chk("rw_err_clear", 32'(p1_err), 32'd0);

        // Asynchronous reset in the middle of a D read burst.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dc_rd   = 1'b1;
            dc_addr = 16'(16'h8000 + k);
            #1;
        end
        chk("ar_pre_rvalid", 32'(p1_dc_rvalid), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("ar_dc_grant",  32'(p1_dc_grant),  32'd0);
        chk("ar_dc_rvalid", 32'(p1_dc_rvalid), 32'd0);
        chk("ar_mem_rd",    32'(p1_mem_rd),    32'd0);
        chk("ar_dc_stall",  32'(p1_dc_stall),  32'd1);
        @(negedge clk);
        rst   = 1'b1;
        dc_rd = 1'b0;
        #1;
        chk("ar_post_grant",  32'(p1_dc_grant),  32'd0);
        chk("ar_post_rvalid", 32'(p1_dc_rvalid), 32'd0);
        @(negedge clk);
        #1;
        chk("ar_post_rvalid2", 32'(p1_dc_rvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
